// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver clocked at OVERSAMPLE x baud.
// Start bit is confirmed at its midpoint, then data and stop bits are
// sampled once per bit period from that point. Completed bytes are held
// in data with a valid/ack handshake; overrun is sticky until reset.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for rx_s low
// START     | counting to mid start bit, confirm low or drop as glitch
// DATA      | sampling 8 data bits LSB first, one per bit period
// STOP      | sampling stop bit, load byte or flag frame error
// WAIT_IDLE | bad stop seen, wait for line to return high (break safe)
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       s_tick,
  input  logic       reset_n,
  input  logic       rx,
  input  logic       data_ack,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       rx_done,
  output logic       frame_error,
  output logic       overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_TC = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_TC = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      idx, idx_nxt;
  logic [7:0]      shift, shift_nxt;
  logic [7:0]      data_nxt;
  logic            data_valid_nxt, rx_done_nxt, frame_error_nxt, overrun_nxt;
  logic            rx_meta, rx_s;
  logic            load;

  // two-flop synchronizer; resets to idle-high so reset never looks like a start edge
  always_ff @(posedge s_tick or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // state, counters and registered outputs
  always_ff @(posedge s_tick or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      data        <= '0;
      data_valid  <= 1'b0;
      rx_done     <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      shift       <= shift_nxt;
      data        <= data_nxt;
      data_valid  <= data_valid_nxt;
      rx_done     <= rx_done_nxt;
      frame_error <= frame_error_nxt;
      overrun     <= overrun_nxt;
    end
  end

  // next-state, bit sampling and output handshake
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    idx_nxt         = idx;
    shift_nxt       = shift;
    data_nxt        = data;
    data_valid_nxt  = data_valid;
    rx_done_nxt     = 1'b0;
    frame_error_nxt = 1'b0;
    overrun_nxt     = overrun;
    load            = 1'b0;

    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (cnt == HALF_TC) begin
          cnt_nxt = '0;
          if (!rx_s) begin
            state_nxt = DATA;
            idx_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == FULL_TC) begin
          cnt_nxt        = '0;
          shift_nxt[idx] = rx_s;
          if (idx == 3'd7) state_nxt = STOP;
          else             idx_nxt   = idx + 3'd1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == FULL_TC) begin
          cnt_nxt = '0;
          if (rx_s) begin
            load      = 1'b1;
            state_nxt = IDLE;
          end else begin
            frame_error_nxt = 1'b1;
            state_nxt       = WAIT_IDLE;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase

    // a load in the same cycle as an ack wins, so the new byte stays valid
    if (load) begin
      data_nxt       = shift;
      rx_done_nxt    = 1'b1;
      data_valid_nxt = 1'b1;
      if (data_valid && !data_ack) overrun_nxt = 1'b1;
    end else if (data_ack) begin
      data_valid_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at OVERSAMPLE=16: a frame table plus
// hand sequences for glitch, break, back-to-back, reset and ack/load race.
module tb_uart_rx;

  localparam int OS = 16;

  logic       s_tick = 1'b0;
  logic       reset_n;
  logic       rx;
  logic       data_ack;
  logic [7:0] data;
  logic       data_valid, rx_done, frame_error, overrun;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int done_cnt = 0;
  int fe_cnt = 0;
  int last_done_cyc = 0;
  int t_fall = 0;

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .s_tick      (s_tick),
    .reset_n     (reset_n),
    .rx          (rx),
    .data_ack    (data_ack),
    .data        (data),
    .data_valid  (data_valid),
    .rx_done     (rx_done),
    .frame_error (frame_error),
    .overrun     (overrun)
  );

  always #5 s_tick = ~s_tick;

  always @(posedge s_tick) cyc <= cyc + 1;

  always @(negedge s_tick) begin
    if (rx_done) begin
      done_cnt = done_cnt + 1;
      last_done_cyc = cyc;
    end
    if (frame_error) fe_cnt = fe_cnt + 1;
  end

  typedef struct {
    logic [7:0] byte_in;
    logic       stop;
    logic       ack_after;
    logic [7:0] exp_data;
    logic       exp_dv;
    logic       exp_ovr;
    int         exp_done;
    int         exp_fe;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    vecs = vecs + 1;
    if (act !== exp) begin
      errs = errs + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int low_after, input int gap);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    @(negedge s_tick);
    t_fall = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (OS) @(negedge s_tick);
    end
    if (low_after > 0) begin
      rx = 1'b0;
      repeat (low_after) @(negedge s_tick);
    end
    rx = 1'b1;
    repeat (gap) @(negedge s_tick);
  endtask

  task automatic ack_pulse(input string name);
    @(negedge s_tick);
    data_ack = 1'b1;
    @(negedge s_tick);
    data_ack = 1'b0;
    chk(name, int'(data_valid), 0);
  endtask

  int d0, f0, lat;
  logic [7:0] exp_d;
  logic seen;

  initial begin
    tbl[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1, 0};
    tbl[1] = '{8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 0, 1};
    tbl[2] = '{8'h81, 1'b1, 1'b0, 8'h81, 1'b1, 1'b0, 1, 0};
    tbl[3] = '{8'h11, 1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 1, 0};
    tbl[4] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1, 0};
    tbl[5] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1, 0};
    tbl[6] = '{8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 0, 1};

    reset_n  = 1'b0;
    rx       = 1'b1;
    data_ack = 1'b0;
    repeat (4) @(negedge s_tick);
    chk("rst_data", int'(data), 0);
    chk("rst_dv", int'(data_valid), 0);
    chk("rst_done", int'(rx_done), 0);
    chk("rst_fe", int'(frame_error), 0);
    chk("rst_ovr", int'(overrun), 0);
    reset_n = 1'b1;
    repeat (4) @(negedge s_tick);

    // frame table
    for (int i = 0; i < 7; i++) begin
      d0 = done_cnt;
      f0 = fe_cnt;
      send_frame(tbl[i].byte_in, tbl[i].stop, 0, 20);
      chk($sformatf("v%0d_data", i), int'(data), int'(tbl[i].exp_data));
      chk($sformatf("v%0d_dv", i), int'(data_valid), int'(tbl[i].exp_dv));
      chk($sformatf("v%0d_ovr", i), int'(overrun), int'(tbl[i].exp_ovr));
      chk($sformatf("v%0d_done", i), done_cnt - d0, tbl[i].exp_done);
      chk($sformatf("v%0d_fe", i), fe_cnt - f0, tbl[i].exp_fe);
      if (tbl[i].exp_done == 1) begin
        lat = last_done_cyc - t_fall;
        chk($sformatf("v%0d_latency(%0d)", i, lat), int'(lat >= 153 && lat <= 155), 1);
      end
      if (tbl[i].ack_after) ack_pulse($sformatf("v%0d_ack_dv", i));
    end

    // short low glitch on idle line
    d0 = done_cnt;
    f0 = fe_cnt;
    @(negedge s_tick);
    rx = 1'b0;
    repeat (4) @(negedge s_tick);
    rx = 1'b1;
    repeat (60) @(negedge s_tick);
    chk("glitch_done", done_cnt - d0, 0);
    chk("glitch_fe", fe_cnt - f0, 0);
    chk("glitch_data", int'(data), 8'hFF);

    // reset during data bit 4 of 0xFF
    d0 = done_cnt;
    f0 = fe_cnt;
    @(negedge s_tick);
    rx = 1'b0;
    repeat (OS) @(negedge s_tick);
    rx = 1'b1;
    repeat (4 * OS + OS / 2) @(negedge s_tick);
    reset_n = 1'b0;
    repeat (3) @(negedge s_tick);
    chk("mrst_data", int'(data), 0);
    chk("mrst_dv", int'(data_valid), 0);
    chk("mrst_ovr", int'(overrun), 0);
    chk("mrst_done", int'(rx_done), 0);
    chk("mrst_fe", int'(frame_error), 0);
    reset_n = 1'b1;
    repeat (200) @(negedge s_tick);
    chk("mrst_no_done", done_cnt - d0, 0);
    chk("mrst_no_fe", fe_cnt - f0, 0);
    send_frame(8'h5A, 1'b1, 0, 20);
    chk("post_rst_data", int'(data), 8'h5A);
    chk("post_rst_dv", int'(data_valid), 1);
    chk("post_rst_done", done_cnt - d0, 1);

    // bad stop then line held low 40 cycles: single frame_error
    ack_pulse("brk_pre_ack");
    f0 = fe_cnt;
    d0 = done_cnt;
    send_frame(8'h3C, 1'b0, 40, 20);
    chk("brk_fe_once", fe_cnt - f0, 1);
    chk("brk_dv", int'(data_valid), 0);
    chk("brk_data", int'(data), 8'h5A);
    chk("brk_no_done", done_cnt - d0, 0);
    send_frame(8'h81, 1'b1, 0, 20);
    chk("brk_next_data", int'(data), 8'h81);
    chk("brk_next_dv", int'(data_valid), 1);

    // back-to-back frames without ack
    ack_pulse("b2b_pre_ack");
    d0 = done_cnt;
    send_frame(8'h11, 1'b1, 0, 0);
    send_frame(8'h22, 1'b1, 0, 20);
    chk("b2b_done", done_cnt - d0, 2);
    chk("b2b_data", int'(data), 8'h22);
    chk("b2b_ovr", int'(overrun), 1);
    chk("b2b_dv", int'(data_valid), 1);
    ack_pulse("b2b_ack_dv");
    chk("b2b_ovr_sticky", int'(overrun), 1);

    // ack held high across the load edge: load wins
    seen = 1'b0;
    fork
      send_frame(8'h77, 1'b1, 0, 20);
      begin
        data_ack = 1'b1;
        for (int k = 0; k < 400 && !seen; k++) begin
          @(negedge s_tick);
          if (rx_done) seen = 1'b1;
        end
        chk("race_seen_done", int'(seen), 1);
        chk("race_dv", int'(data_valid), 1);
        chk("race_data", int'(data), 8'h77);
        data_ack = 1'b0;
      end
    join
    chk("race_dv_hold", int'(data_valid), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
